reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Shares one 16-bit load/reset register (ports clk, rst, load, in, out) between two independent write requesters, e.g. the CPU write-back path and an I/O poller.
- Drives the register's rst/load/in pins and returns its out value to both requesters.
- Arbitrates with round-robin priority and a req/ack handshake.
- Adds a prioritised clear command and a write counter for debug.

Parameters:
- WIDTH, 16, data width of the shared register and of each write port.
- CNT_W, 8, width of the completed-write counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 write request, level, held until ack0.
- wdata0  in  WIDTH  requester 0 write data.
- ack0  out  1  one-cycle pulse: requester 0 write committed.
- req1  in  1  requester 1 write request.
- wdata1  in  WIDTH  requester 1 write data.
- ack1  out  1  one-cycle pulse: requester 1 write committed.
- clr_req  in  1  clear request, level, held until clr_ack.
- clr_ack  out  1  one-cycle pulse: clear committed.
- reg_rst  out  1  to register rst (active-high, synchronous in register).
- reg_load  out  1  to register load.
- reg_in  out  WIDTH  to register in.
- reg_out  in  WIDTH  from register out.
- rdata  out  WIDTH  reg_out passed through combinationally.
- busy  out  1  high whenever state != IDLE.
- wr_count  out  CNT_W  number of completed data writes, wraps.

Behaviour:
- States:
  - IDLE: grant decision.
  - LOAD: reg_load=1.
  - CLEAR: reg_rst=1.
  - ACK: pulse ack/clr_ack.
- Reset (rst_n=0, async):
  - state=IDLE; ack0=ack1=clr_ack=0; reg_load=0; busy=0; wr_count=0; hold register=0.
  - last_grant=1, so requester 0 wins the first tie.
  - reg_rst = 1 while rst_n=0 (combinational OR with state==CLEAR), so the register is cleared too.
- IDLE, evaluated on a rising edge, with clr_req taking priority over req0/req1:
  - clr_req=1: go to CLEAR.
  - Else, only one reqN high: grant it.
  - Else, both high: grant requester != last_grant.
  - On a data grant: latch wdataN into the hold register, record the winner, update last_grant, go to LOAD.
  - No request: stay in IDLE.
- LOAD, exactly 1 cycle:
  - reg_load=1, reg_in=hold (hold is driven on reg_in in every state).
  - wr_count += 1 at the exit edge, wrapping 2^CNT_W-1 -> 0.
  - Go to ACK.
- CLEAR, exactly 1 cycle: reg_rst=1, reg_load=0, go to ACK; wr_count unchanged.
- ACK, exactly 1 cycle:
  - Pulse the winner's ack, or clr_ack; all other acks stay 0.
  - reg_out already holds the new value here.
  - Go to IDLE.
- Latency: req sampled at edge E → LOAD during cycle E..E+1 → ack high in cycle E+1..E+2.
  - Minimum spacing between committed operations is 3 cycles.
- Data is sampled only at the grant edge. Changes to wdataN after grant have no effect on the in-flight write.
- A requester must drop req in the ack cycle. If req is still high at the next IDLE sample, it is treated as a new request.
- A req deasserted before being granted is dropped with no side effects.
- Outputs reg_load, reg_rst (state part), acks and busy are decoded from registered state only. No combinational path from req to ack.
- rst_n asserted mid-LOAD or mid-ACK: the operation is aborted, no ack is issued, and the register is cleared via reg_rst.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release → reg_rst=1 during reset, rdata=0000, busy=0, wr_count=00.
- Single write: req0=1, wdata0=abcd → LOAD next cycle with reg_in=abcd; ack0 one cycle later with rdata=abcd; wr_count=01.
- Contention: req0=req1=1 held, wdata0=1111, wdata1=2222 from reset → order is 0 then 1 (acks 3 cycles apart); rdata ends 2222; wr_count=02.
- Clear priority: rdata=abcd, then clr_req=req1=1 together → CLEAR first, clr_ack, rdata=0000; then req1 served; wr_count increments only for req1.
- Data stability: grant with wdata0=00ff, then change wdata0 to ff00 during LOAD → rdata=00ff.
- Abort and wrap:
  - rst_n=0 during LOAD → no ack, rdata=0000, wr_count=00.
  - Separately, 256 writes → wr_count wraps to 00.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin req/ack arbiter sharing one load/reset register between two writers,
// with a priority clear command and a wrapping completed-write counter.
module reg_write_arbiter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] wdata0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] wdata1,
    output logic             ack1,
    input  logic             clr_req,
    output logic             clr_ack,
    output logic             reg_rst,
    output logic             reg_load,
    output logic [WIDTH-1:0] reg_in,
    input  logic [WIDTH-1:0] reg_out,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic [CNT_W-1:0] wr_count
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] CLEAR = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] hold;
    logic             winner, is_clr, last_grant;
    logic             grant;

    // on a tie the requester that did not win last time gets the slot
    assign grant = (req0 & req1) ? ~last_grant : req1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold       <= '0;
            winner     <= 1'b0;
            is_clr     <= 1'b0;
            last_grant <= 1'b1;
            wr_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        is_clr <= 1'b1;
                        state  <= CLEAR;
                    end else if (req0 | req1) begin
                        is_clr     <= 1'b0;
                        winner     <= grant;
                        last_grant <= grant;
                        hold       <= grant ? wdata1 : wdata0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    wr_count <= wr_count + 1'b1;
                    state    <= ACK;
                end
                CLEAR:   state <= ACK;
                default: state <= IDLE;
            endcase
        end
    end

    assign reg_load = state == LOAD;
    assign reg_rst  = !rst_n || state == CLEAR;
    assign reg_in   = hold;
    assign rdata    = reg_out;
    assign busy     = state != IDLE;
    assign clr_ack  = state == ACK && is_clr;
    assign ack0     = state == ACK && !is_clr && !winner;
    assign ack1     = state == ACK && !is_clr && winner;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: table-driven per-cycle vectors against a behavioural load/reset register,
// plus a 256-write counter wrap sequence.
module tb_reg_write_arbiter;
    logic        clk = 1'b0;
    logic        rst_n, req0, req1, clr_req;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1, clr_ack, reg_rst, reg_load, busy;
    logic [15:0] reg_in, reg_out, rdata;
    logic [7:0]  wr_count;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    reg_write_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .wdata1(wdata1), .ack1(ack1),
        .clr_req(clr_req), .clr_ack(clr_ack),
        .reg_rst(reg_rst), .reg_load(reg_load), .reg_in(reg_in), .reg_out(reg_out),
        .rdata(rdata), .busy(busy), .wr_count(wr_count)
    );

    // the shared 16-bit register: synchronous active-high rst, then load
    always @(posedge clk) begin
        if (reg_rst) reg_out <= 16'h0000;
        else if (reg_load) reg_out <= reg_in;
    end

    typedef struct {
        logic        rn, r0;
        logic [15:0] d0;
        logic        r1;
        logic [15:0] d1;
        logic        c;
        logic        a0, a1, ca, ld, rr, bz;
        logic [15:0] rd, ri;
        logic [7:0]  wc;
    } vec_t;

    vec_t tv[25];

    function automatic vec_t v(input logic rn, r0, input logic [15:0] d0, input logic r1,
                               input logic [15:0] d1, input logic c, a0, a1, ca, ld, rr, bz,
                               input logic [15:0] rd, ri, input logic [7:0] wc);
        vec_t t;
        t.rn = rn; t.r0 = r0; t.d0 = d0; t.r1 = r1; t.d1 = d1; t.c = c;
        t.a0 = a0; t.a1 = a1; t.ca = ca; t.ld = ld; t.rr = rr; t.bz = bz;
        t.rd = rd; t.ri = ri; t.wc = wc;
        return t;
    endfunction

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endtask

    initial begin
        int timeouts;
        logic got;
        // inputs: rn r0 d0 r1 d1 clr | expected: ack0 ack1 clr_ack load rst busy rdata reg_in wr_count
        tv[0]  = v(0, 0, 16'h0000, 0, 16'h0000, 0,  0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 8'h00);
        tv[1]  = v(0, 0, 16'h0000, 0, 16'h0000, 0,  0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 8'h00);
        tv[2]  = v(1, 0, 16'h0000, 0, 16'h0000, 0,  0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 8'h00);
        tv[3]  = v(1, 1, 16'habcd, 0, 16'h0000, 0,  0, 0, 0, 1, 0, 1, 16'h0000, 16'habcd, 8'h00);
        tv[4]  = v(1, 1, 16'habcd, 0, 16'h0000, 0,  1, 0, 0, 0, 0, 1, 16'habcd, 16'habcd, 8'h01);
        tv[5]  = v(1, 0, 16'habcd, 0, 16'h0000, 0,  0, 0, 0, 0, 0, 0, 16'habcd, 16'habcd, 8'h01);
        tv[6]  = v(1, 0, 16'h0000, 1, 16'h5555, 1,  0, 0, 0, 0, 1, 1, 16'habcd, 16'habcd, 8'h01);
        tv[7]  = v(1, 0, 16'h0000, 1, 16'h5555, 1,  0, 0, 1, 0, 0, 1, 16'h0000, 16'habcd, 8'h01);
        tv[8]  = v(1, 0, 16'h0000, 1, 16'h5555, 0,  0, 0, 0, 0, 0, 0, 16'h0000, 16'habcd, 8'h01);
        tv[9]  = v(1, 0, 16'h0000, 1, 16'h5555, 0,  0, 0, 0, 1, 0, 1, 16'h0000, 16'h5555, 8'h01);
        tv[10] = v(1, 0, 16'h0000, 1, 16'h5555, 0,  0, 1, 0, 0, 0, 1, 16'h5555, 16'h5555, 8'h02);
        tv[11] = v(1, 0, 16'h0000, 0, 16'h5555, 0,  0, 0, 0, 0, 0, 0, 16'h5555, 16'h5555, 8'h02);
        tv[12] = v(1, 1, 16'h00ff, 0, 16'h0000, 0,  0, 0, 0, 1, 0, 1, 16'h5555, 16'h00ff, 8'h02);
        tv[13] = v(1, 1, 16'hff00, 0, 16'h0000, 0,  1, 0, 0, 0, 0, 1, 16'h00ff, 16'h00ff, 8'h03);
        tv[14] = v(1, 0, 16'hff00, 0, 16'h0000, 0,  0, 0, 0, 0, 0, 0, 16'h00ff, 16'h00ff, 8'h03);
        tv[15] = v(0, 0, 16'h0000, 0, 16'h0000, 0,  0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 8'h00);
        tv[16] = v(1, 1, 16'h1111, 1, 16'h2222, 0,  0, 0, 0, 1, 0, 1, 16'h0000, 16'h1111, 8'h00);
        tv[17] = v(1, 1, 16'h1111, 1, 16'h2222, 0,  1, 0, 0, 0, 0, 1, 16'h1111, 16'h1111, 8'h01);
        tv[18] = v(1, 0, 16'h1111, 1, 16'h2222, 0,  0, 0, 0, 0, 0, 0, 16'h1111, 16'h1111, 8'h01);
        tv[19] = v(1, 0, 16'h1111, 1, 16'h2222, 0,  0, 0, 0, 1, 0, 1, 16'h1111, 16'h2222, 8'h01);
        tv[20] = v(1, 0, 16'h1111, 1, 16'h2222, 0,  0, 1, 0, 0, 0, 1, 16'h2222, 16'h2222, 8'h02);
        tv[21] = v(1, 0, 16'h1111, 0, 16'h2222, 0,  0, 0, 0, 0, 0, 0, 16'h2222, 16'h2222, 8'h02);
        tv[22] = v(1, 1, 16'hbeef, 0, 16'h0000, 0,  0, 0, 0, 1, 0, 1, 16'h2222, 16'hbeef, 8'h02);
        tv[23] = v(0, 1, 16'hbeef, 0, 16'h0000, 0,  0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 8'h00);
        tv[24] = v(1, 0, 16'h0000, 0, 16'h0000, 0,  0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 8'h00);

        for (int i = 0; i < 25; i++) begin
            rst_n = tv[i].rn; req0 = tv[i].r0; wdata0 = tv[i].d0;
            req1 = tv[i].r1; wdata1 = tv[i].d1; clr_req = tv[i].c;
            @(negedge clk);
            chk($sformatf("v%0d_ack0", i), {15'd0, ack0}, {15'd0, tv[i].a0});
            chk($sformatf("v%0d_ack1", i), {15'd0, ack1}, {15'd0, tv[i].a1});
            chk($sformatf("v%0d_clr_ack", i), {15'd0, clr_ack}, {15'd0, tv[i].ca});
            chk($sformatf("v%0d_reg_load", i), {15'd0, reg_load}, {15'd0, tv[i].ld});
            chk($sformatf("v%0d_reg_rst", i), {15'd0, reg_rst}, {15'd0, tv[i].rr});
            chk($sformatf("v%0d_busy", i), {15'd0, busy}, {15'd0, tv[i].bz});
            chk($sformatf("v%0d_rdata", i), rdata, tv[i].rd);
            chk($sformatf("v%0d_reg_in", i), reg_in, tv[i].ri);
            chk($sformatf("v%0d_wr_count", i), {8'd0, wr_count}, {8'd0, tv[i].wc});
        end

        // 256 back-to-back writes from requester 0: counter must wrap to zero
        timeouts = 0;
        for (int i = 0; i < 256; i++) begin
            req0 = 1'b1;
            wdata0 = i[15:0];
            got = 1'b0;
            for (int k = 0; k < 6 && !got; k++) begin
                @(negedge clk);
                if (ack0) got = 1'b1;
            end
            req0 = 1'b0;
            if (!got) timeouts++;
            @(negedge clk);
            if (i == 254) chk("wrap_count_255", {8'd0, wr_count}, 16'h00ff);
        end
        chk("wrap_timeouts", timeouts[15:0], 16'd0);
        chk("wrap_count_0", {8'd0, wr_count}, 16'h0000);
        chk("wrap_rdata", rdata, 16'h00ff);
        chk("wrap_busy", {15'd0, busy}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
